seq_monitor: RTL and testbench

SEQ_MONITOR -- requirements
Module: seq_monitor

---
 rtl/seq_mon_pkg.sv | 29 ++
 rtl/seq_mon_next.sv | 47 ++++
 rtl/seq_monitor.sv | 102 ++++++++++
 tb/tb_seq_monitor.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/seq_mon_pkg.sv
// Shared constants for the sequence monitor: code values, error causes, state encoding.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package seq_mon_pkg;

  // Legal codes emitted by the upstream sequence FSM.
  localparam logic [2:0] CODE_0 = 3'd0;
  localparam logic [2:0] CODE_2 = 3'd2;
  localparam logic [2:0] CODE_3 = 3'd3;
  localparam logic [2:0] CODE_4 = 3'd4;
  localparam logic [2:0] CODE_5 = 3'd5;

  // Error causes reported on err_code.
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_CODE  = 2'b01;  // code outside the legal set
  localparam logic [1:0] ERR_TRANS = 2'b10;  // illegal prev->current pair
  localparam logic [1:0] ERR_PRED  = 2'b11;  // legal pair, wrong branch taken

  // Monitor state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_ERROR = 2'd2;

  function automatic logic is_legal_code(input logic [2:0] c);
    return (c == CODE_0) || (c == CODE_2) || (c == CODE_3) ||
           (c == CODE_4) || (c == CODE_5);
  endfunction

endpackage

// File: rtl/seq_mon_next.sv
// Transition table: legality of prev->s and the code the upstream FSM should emit next.
// Latency: purely combinational.
// Backpressure: none.
// Ports: prev (last sampled code), a (branch input seen with prev), s (current
//        sample) -> legal (prev->s allowed), pred (expected s given prev and a).
module seq_mon_next
  import seq_mon_pkg::*;
(
  input  logic [2:0] prev,
  input  logic       a,
  input  logic [2:0] s,
  output logic       legal,
  output logic [2:0] pred
);

  always_comb begin
    legal = 1'b0;
    pred  = CODE_0;
    case (prev)
      CODE_0: begin
        legal = (s == CODE_3);
        pred  = CODE_3;
      end
      CODE_3: begin
        legal = (s == CODE_5) || (s == CODE_2);
        pred  = a ? CODE_5 : CODE_2;
      end
      CODE_5: begin
        legal = (s == CODE_2);
        pred  = CODE_2;
      end
      CODE_2: begin
        legal = (s == CODE_4);
        pred  = CODE_4;
      end
      CODE_4: begin
        legal = (s == CODE_3) || (s == CODE_0);
        pred  = a ? CODE_3 : CODE_0;
      end
      default: begin
        legal = 1'b0;
        pred  = CODE_0;
      end
    endcase
  end

endmodule

// File: rtl/seq_monitor.sv
// Watches the code stream of the upstream sequence FSM, flags the first illegal
// code/transition (sticky) and counts completed 4->0 loops (saturating).
// Latency: all outputs registered, visible one clk edge after the sample. Backpressure: none.
// Ports: clk, reset (async active-low), saida (code stream), a (upstream branch
//        input), clr (sync clear) -> err, err_code, loops[CNT_W], prev.
// Build option: define SEQ_MON_PRED_EN to also check that the branch taken out of
// codes 3 and 4 matches the a value seen on the previous edge (err_code 11).
module seq_monitor
  import seq_mon_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       saida,
  input  logic             a,
  input  logic             clr,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] loops,
  output logic [2:0]       prev
);

`ifdef SEQ_MON_PRED_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  logic [1:0] state;
  // a from the edge that sampled prev: the upstream FSM chose the current code with it.
  logic       a_q;
  logic       legal_trans;
  logic [2:0] pred;
  logic       pred_miss;

  seq_mon_next u_next (
    .prev  (prev),
    .a     (a_q),
    .s     (saida),
    .legal (legal_trans),
    .pred  (pred)
  );

  assign pred_miss = PRED_EN && (saida != pred);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      loops    <= '0;
      prev     <= CODE_0;
      a_q      <= 1'b0;
    end else begin
      // prev tracks the stream in every state, including ERROR.
      prev <= saida;
      a_q  <= a;
      if (clr) begin
        // clr wins over any error seen on the same edge.
        err      <= 1'b0;
        err_code <= ERR_NONE;
        loops    <= '0;
        state    <= is_legal_code(saida) ? ST_TRACK : ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (saida == CODE_0) begin
              state <= ST_TRACK;
            end else begin
              state    <= ST_ERROR;
              err      <= 1'b1;
              err_code <= is_legal_code(saida) ? ERR_TRANS : ERR_CODE;
            end
          end
          ST_TRACK: begin
            if (!is_legal_code(saida)) begin
              state    <= ST_ERROR;
              err      <= 1'b1;
              err_code <= ERR_CODE;
            end else if (!legal_trans) begin
              state    <= ST_ERROR;
              err      <= 1'b1;
              err_code <= ERR_TRANS;
            end else if (pred_miss) begin
              state    <= ST_ERROR;
              err      <= 1'b1;
              err_code <= ERR_PRED;
            end else if ((prev == CODE_4) && (saida == CODE_0) && (loops != '1)) begin
              loops <= loops + CNT_W'(1);
            end
          end
          ST_ERROR: begin
            // Frozen until clr or reset; first cause is kept.
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_monitor.sv
// Directed bench for seq_monitor: two instances (CNT_W=8 and CNT_W=2) share stimulus.
// Each step queues its expected outputs, drives one sample, then checks one edge later.
module tb_seq_monitor;

`ifdef SEQ_MON_PRED_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [2:0] saida;
  logic       a;
  logic       clr;

  logic       err8, err2;
  logic [1:0] code8, code2;
  logic [7:0] loops8;
  logic [1:0] loops2;
  logic [2:0] prev8, prev2;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    string      tag;
    logic       err;
    logic [1:0] code;
    int         l8;
    int         l2;
    logic [2:0] prev;
  } exp_t;

  exp_t sb[$];

  seq_monitor u8 (
    .clk(clk), .reset(reset), .saida(saida), .a(a), .clr(clr),
    .err(err8), .err_code(code8), .loops(loops8), .prev(prev8)
  );

  seq_monitor #(.CNT_W(2)) u2 (
    .clk(clk), .reset(reset), .saida(saida), .a(a), .clr(clr),
    .err(err2), .err_code(code2), .loops(loops2), .prev(prev2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".err8"},   32'(err8),   0);
    chk({tag, ".code8"},  32'(code8),  0);
    chk({tag, ".loops8"}, 32'(loops8), 0);
    chk({tag, ".prev8"},  32'(prev8),  0);
    chk({tag, ".err2"},   32'(err2),   0);
    chk({tag, ".loops2"}, 32'(loops2), 0);
    chk({tag, ".prev2"},  32'(prev2),  0);
  endtask

  // One sample: queue expectation, drive inputs, compare one edge later.
  task automatic step(input string tag, input logic [2:0] s, input logic av, input logic c,
                      input logic e, input logic [1:0] ec, input int l8, input int l2);
    exp_t x;
    exp_t y;
    x.tag = tag; x.err = e; x.code = ec; x.l8 = l8; x.l2 = l2; x.prev = s;
    sb.push_back(x);
    saida = s;
    a     = av;
    clr   = c;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_err++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      y = sb.pop_front();
      chk({y.tag, ".err8"},   32'(err8),   32'(y.err));
      chk({y.tag, ".code8"},  32'(code8),  32'(y.code));
      chk({y.tag, ".loops8"}, 32'(loops8), y.l8);
      chk({y.tag, ".prev8"},  32'(prev8),  32'(y.prev));
      chk({y.tag, ".err2"},   32'(err2),   32'(y.err));
      chk({y.tag, ".code2"},  32'(code2),  32'(y.code));
      chk({y.tag, ".loops2"}, 32'(loops2), y.l2);
    end
    clr = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    saida = 3'd0;
    a     = 1'b0;
    clr   = 1'b0;
    #12;
    chk_all_zero("reset_init");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // a=0 loop 0,3,2,4,0 five times; loops counts 1..5, CNT_W=2 saturates at 3.
    step("a0_first0", 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      step("a0_s3", 3'd3, 1'b0, 1'b0, 1'b0, 2'b00, i - 1, (i - 1 > 3) ? 3 : i - 1);
      step("a0_s2", 3'd2, 1'b0, 1'b0, 1'b0, 2'b00, i - 1, (i - 1 > 3) ? 3 : i - 1);
      step("a0_s4", 3'd4, 1'b0, 1'b0, 1'b0, 2'b00, i - 1, (i - 1 > 3) ? 3 : i - 1);
      step("a0_s0", 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, i, (i > 3) ? 3 : i);
    end

    // a=1 path 3,5,2,4,3,...: no error, no counting.
    step("a1_s3",  3'd3, 1'b1, 1'b0, 1'b0, 2'b00, 5, 3);
    step("a1_s5",  3'd5, 1'b1, 1'b0, 1'b0, 2'b00, 5, 3);
    step("a1_s2",  3'd2, 1'b1, 1'b0, 1'b0, 2'b00, 5, 3);
    step("a1_s4",  3'd4, 1'b1, 1'b0, 1'b0, 2'b00, 5, 3);
    step("a1_s3b", 3'd3, 1'b1, 1'b0, 1'b0, 2'b00, 5, 3);
    step("a1_s5b", 3'd5, 1'b1, 1'b0, 1'b0, 2'b00, 5, 3);
    step("a1_s2b", 3'd2, 1'b1, 1'b0, 1'b0, 2'b00, 5, 3);
    step("a1_s4b", 3'd4, 1'b1, 1'b0, 1'b0, 2'b00, 5, 3);
    step("a1_s3c", 3'd3, 1'b1, 1'b0, 1'b0, 2'b00, 5, 3);

    // Illegal code 6 in TRACK; then error state is frozen, prev keeps following.
    step("bad6",     3'd6, 1'b0, 1'b0, 1'b1, 2'b01, 5, 3);
    step("frz_s5",   3'd5, 1'b0, 1'b0, 1'b1, 2'b01, 5, 3);
    step("frz_s2",   3'd2, 1'b0, 1'b0, 1'b1, 2'b01, 5, 3);
    step("frz_s4",   3'd4, 1'b0, 1'b0, 1'b1, 2'b01, 5, 3);
    step("frz_s0",   3'd0, 1'b0, 1'b0, 1'b1, 2'b01, 5, 3);
    step("frz_s3",   3'd3, 1'b0, 1'b0, 1'b1, 2'b01, 5, 3);

    // clr, then illegal pair 3->4, then clr re-arms TRACK.
    step("clr1",     3'd0, 1'b0, 1'b1, 1'b0, 2'b00, 0, 0);
    step("t_s3",     3'd3, 1'b0, 1'b0, 1'b0, 2'b00, 0, 0);
    step("t_34",     3'd4, 1'b0, 1'b0, 1'b1, 2'b10, 0, 0);
    step("clr2",     3'd0, 1'b0, 1'b1, 1'b0, 2'b00, 0, 0);
    step("rearm_s3", 3'd3, 1'b0, 1'b0, 1'b0, 2'b00, 0, 0);

    // clr with an illegal sample: no error, back to IDLE; next 3 is a bad first sample.
    step("clr_bad7", 3'd7, 1'b0, 1'b1, 1'b0, 2'b00, 0, 0);
    step("idle_s3",  3'd3, 1'b0, 1'b0, 1'b1, 2'b10, 0, 0);
    step("clr3",     3'd0, 1'b0, 1'b1, 1'b0, 2'b00, 0, 0);
    step("self_00",  3'd0, 1'b0, 1'b0, 1'b1, 2'b10, 0, 0);
    step("clr4",     3'd0, 1'b0, 1'b1, 1'b0, 2'b00, 0, 0);

    // a=1 at the edge sampling 3, then 2: prediction miss only when enabled.
    step("pred_s3",  3'd3, 1'b1, 1'b0, 1'b0, 2'b00, 0, 0);
    step("pred_s2",  3'd2, 1'b0, 1'b0, PE, PE ? 2'b11 : 2'b00, 0, 0);
    step("clr5",     3'd0, 1'b0, 1'b1, 1'b0, 2'b00, 0, 0);

    // One more loop, then reset mid-loop.
    step("l_s3",  3'd3, 1'b0, 1'b0, 1'b0, 2'b00, 0, 0);
    step("l_s2",  3'd2, 1'b0, 1'b0, 1'b0, 2'b00, 0, 0);
    step("l_s4",  3'd4, 1'b0, 1'b0, 1'b0, 2'b00, 0, 0);
    step("l_s0",  3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1, 1);
    step("l_s3b", 3'd3, 1'b0, 1'b0, 1'b0, 2'b00, 1, 1);
    step("l_s2b", 3'd2, 1'b0, 1'b0, 1'b0, 2'b00, 1, 1);

    saida = 3'd5;
    reset = 1'b0;
    #2;
    chk_all_zero("rst_async");
    @(posedge clk);
    #1;
    chk_all_zero("rst_held");
    reset = 1'b1;
    step("post_rst_s3", 3'd3, 1'b0, 1'b0, 1'b1, 2'b10, 0, 0);

    reset = 1'b0;
    #2;
    reset = 1'b1;
    step("post_rst_s6", 3'd6, 1'b0, 1'b0, 1'b1, 2'b01, 0, 0);
    step("err_keep",    3'd0, 1'b0, 1'b0, 1'b1, 2'b01, 0, 0);

    n_checks++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
